bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential, parametrised packed-BCD to binary converter for the vending-machine datapath.
//  Converts price and credit fields from BCD to binary one digit per clock, MS digit first.
//  Uses shift-add only (acc*10 = acc<<3 + acc<<1), so it needs no wide multipliers.
//  Has a valid/ready handshake on both sides, detects illegal digits, and supports back-to-back words.
// PARAMETERS
//  DIGITS  4   number of BCD digits in in_bcd (>=1)
//  OUT_W   14  result width; must be >= ceil(log2(10**DIGITS)); elaboration error otherwise
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          in_bcd holds a word to convert
//  in_ready   out  1          converter can accept a word this cycle
//  in_bcd     in   4*DIGITS   packed BCD; digit k at [4k+3:4k]; digit DIGITS-1 is most significant
//  out_valid  out  1          out_bin/out_err are valid; held until accepted
//  out_ready  in   1          downstream accepts the result
//  out_bin    out  OUT_W      binary value of in_bcd; 0 when out_err=1
//  out_err    out  1          at least one nibble of the word was >9
// BEHAVIOUR
//  Reset (async assert; sync deassert handled upstream):
//   - state=IDLE; acc, digit count, shift register and err cleared.
//   - out_valid=0, out_bin=0, out_err=0, in_ready=1 while rst is low.
//  State machine:
//   - IDLE: in_ready=1. On in_valid, capture in_bcd into a shift register, acc=0, cnt=0, err=0,
//     then go to CONV.
//   - CONV: in_ready=0. Each cycle, for digit d = top nibble of the shift register:
//     acc <= acc*10 + d; err |= (d>9); shift register <<= 4; cnt++.
//     After DIGITS cycles (cnt==DIGITS-1 processed), go to DONE.
//   - DONE: out_valid=1, out_bin = err ? 0 : acc, out_err = err. Both are held stable until out_ready.
//     On out_ready with no in_valid, go to IDLE.
//  Latency: in_valid&in_ready at edge N gives out_valid high from edge N+DIGITS+1 onward.
//   - With DIGITS=4, out_valid rises 5 clocks after acceptance.
//  Back-to-back:
//   - in_ready = (state==IDLE) | (state==DONE & out_ready).
//   - In DONE with out_ready & in_valid in the same cycle: the result is retired and the new word is
//     captured in that cycle; go straight to CONV with no idle bubble.
//   - Throughput is one word per DIGITS+1 clocks.
//  Arithmetic:
//   - acc is OUT_W bits wide; the *10 is (acc<<3)+(acc<<1) truncated to OUT_W.
//   - No wrap occurs under the OUT_W constraint.
//   - An illegal nibble (A-F) is still accumulated internally; the result is forced to 0 with
//     out_err=1.
//  Boundaries:
//   - in_valid while in CONV is ignored (in_ready=0); upstream must hold the word.
//   - out_ready while out_valid=0 has no effect.
//   - rst asserted mid-CONV or mid-DONE: the conversion is abandoned and no out_valid pulse appears.
//   - All-zero word gives out_bin=0, out_err=0.
//   - All-nines word gives 10**DIGITS-1.
// STRUCTURE
//  Shared header bcd_defs.vh:
//   - state encodings ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2.
//   - constants BCD_MAX=4'd9 and BCD_W=4.
//  One sub-module, bcd_mac10:
//   - combinational: {acc_in[OUT_W-1:0], digit[3:0]} -> acc_out = acc_in*10+digit, plus bad=(digit>9).
//   - Instantiated once; the top level holds the FSM, counter, shift register and output registers.
// TESTING (DIGITS=4, OUT_W=14 unless stated)
//  1. Reset then idle: rst high 3 cycles -> out_valid=0, out_bin=0, in_ready=1 after release.
//  2. Basic conversion:
//     - in_bcd=16'h1234 accepted -> 5 clocks later out_valid=1, out_bin=1234, out_err=0.
//     - out_bin is held until out_ready.
//  3. Extremes: 16'h9999 -> 9999; 16'h0000 -> 0.
//     With DIGITS=6, OUT_W=20: 24'h999999 -> 999999.
//  4. Illegal digit: in_bcd=16'h12A4 -> out_err=1, out_bin=0.
//     The next word 16'h0042 -> out_err=0, out_bin=42.
//  5. Backpressure and back-to-back:
//     - out_ready held low 10 cycles -> out_valid and out_bin stable, in_ready=0.
//     - Then out_ready=1 with in_valid=1 (16'h0500) -> new word accepted that cycle;
//       500 appears DIGITS+1 clocks later.
//  6. Reset mid-operation: assert rst 2 clocks after accepting 16'h7777 -> no out_valid.
//     Afterwards 16'h0001 converts to 1 with normal latency.

Source files
------------

// File: rtl/bcd2bin_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2bin_seq_pkg
//  Purpose  : Shared definitions for the sequential BCD-to-binary converter:
//             FSM state encodings, BCD digit constants and a helper that
//             gives the minimum result width for a given digit count.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package bcd2bin_seq_pkg;

  // Converter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // BCD digit constants
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         BCD_W   = 4;

  // Smallest result width that can hold 10**digits - 1
  function automatic int min_out_w(input int digits);
    longint unsigned lim;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    return $clog2(lim);
  endfunction

endpackage : bcd2bin_seq_pkg
`default_nettype wire

// File: rtl/bcd2bin_seq_mac10.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mac10
//  Purpose  : Combinational multiply-by-ten-and-add step for BCD conversion.
//             acc_out = acc_in*10 + digit, built from two shifts and adds.
//             bad flags a nibble outside the legal BCD range 0..9.
//  Ports    : acc_in  [OUT_W-1:0] running accumulator
//             digit   [3:0]       current BCD nibble
//             acc_out [OUT_W-1:0] acc_in*10 + digit (truncated to OUT_W)
//             bad                 digit > 9
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mac10
  import bcd2bin_seq_pkg::*;
#(
  parameter int OUT_W = 14
) (
  input  logic [OUT_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [OUT_W-1:0] acc_out,
  output logic             bad
);

  logic [OUT_W-1:0] w_x8;
  logic [OUT_W-1:0] w_x2;
  logic [OUT_W-1:0] w_digit_ext;

  // acc*10 = acc*8 + acc*2; bits shifted past OUT_W are dropped on purpose
  assign w_x8        = acc_in << 3;
  assign w_x2        = acc_in << 1;
  assign w_digit_ext = OUT_W'(digit);
  assign acc_out     = w_x8 + w_x2 + w_digit_ext;
  assign bad         = (digit > BCD_MAX);

endmodule : bcd_mac10
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2bin_seq
//  Purpose  : Sequential packed-BCD to binary converter, one digit per clock,
//             most significant digit first, with valid/ready on both sides.
//             Illegal nibbles (A-F) force the result to 0 and raise out_err.
//  Ports    : clk                     rising-edge clock
//             rst                     asynchronous active-high reset
//             in_valid / in_ready     input handshake
//             in_bcd  [4*DIGITS-1:0]  packed BCD word, digit DIGITS-1 is MS
//             out_valid / out_ready   output handshake, result held until taken
//             out_bin [OUT_W-1:0]     binary result (0 when out_err)
//             out_err                 a nibble of the word was > 9
//  Revision : 1.0  initial release
// ============================================================================
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BCD_W*DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_bin,
  output logic                    out_err
);

  localparam int c_sr_w  = BCD_W * DIGITS;
  localparam int c_cnt_w = $clog2(DIGITS + 1);
  // Counter value reached once every digit has been folded into acc
  localparam logic [c_cnt_w-1:0] c_cnt_done = c_cnt_w'(DIGITS);

  generate
    if (DIGITS < 1) begin : g_digits_check
      $error("bcd2bin_seq: DIGITS must be at least 1");
    end
    if (OUT_W < min_out_w(DIGITS)) begin : g_out_w_check
      $error("bcd2bin_seq: OUT_W too narrow for 10**DIGITS-1");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_sr_w-1:0]  r_shift;
  logic [OUT_W-1:0]   r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;

  logic               w_accept;
  logic [3:0]         w_digit;
  logic [OUT_W-1:0]   w_mac_acc;
  logic               w_bad;

  assign w_accept = in_valid & in_ready;
  assign w_digit  = r_shift[c_sr_w-1 -: BCD_W];

  bcd_mac10 #(
    .OUT_W (OUT_W)
  ) u_mac10 (
    .acc_in  (r_acc),
    .digit   (w_digit),
    .acc_out (w_mac_acc),
    .bad     (w_bad)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        // One extra CONV cycle after the last digit lets the result settle
        // in acc before DONE presents it.
        if (r_cnt == c_cnt_done) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = in_valid ? ST_CONV : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    out_valid = (r_state == ST_DONE);
    out_err   = (r_state == ST_DONE) & r_err;
    out_bin   = ((r_state == ST_DONE) && !r_err) ? r_acc : '0;
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, accumulator, digit counter, error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_shift <= in_bcd;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if ((r_state == ST_CONV) && (r_cnt != c_cnt_done)) begin
      r_acc   <= w_mac_acc;
      r_err   <= r_err | w_bad;
      r_shift <= r_shift << BCD_W;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule : bcd2bin_seq
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd2bin_seq
//  Purpose  : Self-checking bench for bcd2bin_seq (DIGITS=4/OUT_W=14 plus a
//             DIGITS=6/OUT_W=20 instance). Expected results are queued when a
//             word is accepted and retired by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd2bin_seq;

  typedef struct {
    int unsigned val;
    bit          err;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_bin;
  logic        out_err;

  logic        d6_in_valid;
  logic        d6_in_ready;
  logic [23:0] d6_in_bcd;
  logic        d6_out_valid;
  logic        d6_out_ready;
  logic [19:0] d6_out_bin;
  logic        d6_out_err;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  exp_t q[$];
  bit   rdy_force;
  bit   rdy_val;

  bcd2bin_seq #(.DIGITS(4), .OUT_W(14)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  bcd2bin_seq #(.DIGITS(6), .OUT_W(20)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d6_in_valid),
    .in_ready  (d6_in_ready),
    .in_bcd    (d6_in_bcd),
    .out_valid (d6_out_valid),
    .out_ready (d6_out_ready),
    .out_bin   (d6_out_bin),
    .out_err   (d6_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value is the positional sum of decimal digits; any nibble
  // above 9 makes the word illegal and the reported value 0.
  function automatic void model(input longint unsigned w, input int nd,
                                output int unsigned val, output bit err);
    longint unsigned sum;
    longint unsigned weight;
    int d;
    sum = 0; weight = 1; err = 1'b0;
    for (int k = 0; k < nd; k++) begin
      d = int'((w >> (4 * k)) & 64'hF);
      if (d > 9) err = 1'b1;
      sum = sum + longint'(d) * weight;
      weight = weight * 10;
    end
    val = err ? 0 : int'(sum);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) w[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return w;
  endfunction

  // Present one word and wait (bounded) for it to be accepted
  task automatic send(input logic [15:0] w, input bit expect_it);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_bcd   = w;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end else if (expect_it) begin
      model(64'(w), 4, e.val, e.err);
      e.acc_cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk); n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Downstream ready: random unless a test pins it
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit          hold_v, prev_v;
    logic [13:0] hold_bin;
    logic        hold_err;
    int          first_cyc;
    exp_t        e;
    hold_v = 0; prev_v = 0; first_cyc = 0; hold_bin = '0; hold_err = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        hold_v = 0; prev_v = 0;
      end else begin
        if (out_valid && !prev_v) first_cyc = cyc;
        if (out_valid && hold_v) begin
          chk("hold_bin", out_bin, hold_bin);
          chk("hold_err", out_err, hold_err);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: got bin=%0d err=%0d expected no result", out_bin, out_err);
          end else begin
            e = q.pop_front();
            chk("out_bin", out_bin, e.val);
            chk("out_err", out_err, e.err);
            chk("latency", first_cyc - e.acc_cyc, 5);
          end
        end
        hold_v   = out_valid && !out_ready;
        hold_bin = out_bin;
        hold_err = out_err;
        prev_v   = out_valid;
      end
    end
  end

  initial begin : main
    logic [15:0] dir[5];
    logic [23:0] w6[3];
    int unsigned v6;
    bit          e6;
    int          n, t0;

    n_cmp = 0; n_bad = 0;
    rdy_force = 1'b0; rdy_val = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_bcd = '0;
    d6_in_valid = 1'b0; d6_in_bcd = '0; d6_out_ready = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_bin", out_bin, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_in_ready", in_ready, 1);

    // Directed words under random backpressure
    dir[0] = 16'h1234; dir[1] = 16'h9999; dir[2] = 16'h0000;
    dir[3] = 16'h12A4; dir[4] = 16'h0042;
    foreach (dir[i]) send(dir[i], 1'b1);

    // Random words, random gaps
    for (int i = 0; i < 150; i++) begin
      send(rand_word(), 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    // Backpressure then back-to-back acceptance
    rdy_force = 1'b1; rdy_val = 1'b0;
    send(16'h1234, 1'b1);
    n = 0;
    @(negedge clk); #1;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
    end
    rdy_val = 1'b1;
    send(16'h0500, 1'b1);
    drain();

    // Reset in the middle of a conversion
    send(16'h7777, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("abandoned_no_valid", out_valid, 0);
    end
    send(16'h0001, 1'b1);
    drain();
    rdy_force = 1'b0;

    // Six-digit instance
    w6[0] = 24'h999999; w6[1] = 24'h123456; w6[2] = 24'h10F000;
    foreach (w6[i]) begin
      model(64'(w6[i]), 6, v6, e6);
      @(negedge clk);
      d6_in_valid = 1'b1; d6_in_bcd = w6[i];
      @(posedge clk); #1;
      d6_in_valid = 1'b0;
      t0 = cyc;
      n = 0;
      @(negedge clk); #2;
      while (!d6_out_valid && n < 20) begin @(negedge clk); #2; n++; end
      chk("d6_latency", cyc - t0, 7);
      chk("d6_out_bin", d6_out_bin, v6);
      chk("d6_out_err", d6_out_err, e6);
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bcd2bin_seq
`default_nettype wire
